// File: rtl/cop_insn_issue.sv
// CPU-side issue/retire sequencer for the CPU/COP instruction interface.
// It issues one decoded coprocessor instruction at a time and holds the
// request stable until the COP acknowledges it. It then waits for the COP
// response and parks the writeback in a one-entry skid register. A sticky
// cop_hang flag reports a response that has taken too long.
module cop_insn_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CW             = 11
) (
  input  logic        g_clk,
  input  logic        g_reset,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [31:0] dec_enc,
  input  logic [31:0] dec_rs1,
  input  logic [31:0] dec_rs2,
  output logic        cpu_insn_req,
  input  logic        cop_insn_ack,
  output logic [31:0] cpu_insn_enc,
  output logic [31:0] cpu_rs1,
  output logic [31:0] cpu_rs2,
  input  logic        cop_insn_rsp,
  output logic        cpu_insn_ack,
  input  logic        cop_wen,
  input  logic [4:0]  cop_waddr,
  input  logic [31:0] cop_wdata,
  input  logic [2:0]  cop_result,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic        wb_wen,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic [2:0]  wb_result,
  output logic        busy,
  output logic        cop_hang
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_HANG = CW'(TIMEOUT_CYCLES - 1);

  state_t        state_q, state_d;
  logic [31:0]   enc_q, enc_d;
  logic [31:0]   rs1_q, rs1_d;
  logic [31:0]   rs2_q, rs2_d;
  logic          wb_valid_q, wb_valid_d;
  logic          wb_wen_q, wb_wen_d;
  logic [4:0]    wb_waddr_q, wb_waddr_d;
  logic [31:0]   wb_wdata_q, wb_wdata_d;
  logic [2:0]    wb_result_q, wb_result_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hang_q, hang_d;
  logic          rsp_take;

  // A response is taken only in WAIT and only if the skid entry is free or
  // draining this cycle. The handshakes are held low while reset is applied.
  assign rsp_take     = (state_q == ST_WAIT) && cop_insn_rsp &&
                        (!wb_valid_q || wb_ready) && !g_reset;
  assign cpu_insn_ack = rsp_take;
  assign cpu_insn_req = (state_q == ST_REQ) && !g_reset;
  assign dec_ready    = (state_q == ST_IDLE) && !g_reset;
  assign busy         = (state_q != ST_IDLE);
  assign cop_hang     = hang_q;
  assign cpu_insn_enc = enc_q;
  assign cpu_rs1      = rs1_q;
  assign cpu_rs2      = rs2_q;
  assign wb_valid     = wb_valid_q;
  assign wb_wen       = wb_wen_q;
  assign wb_waddr     = wb_waddr_q;
  assign wb_wdata     = wb_wdata_q;
  assign wb_result    = wb_result_q;

  // Next-state logic for the sequencer, request latch, skid entry and timeout.
  always_comb begin
    state_d     = state_q;
    enc_d       = enc_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    wb_valid_d  = wb_valid_q;
    wb_wen_d    = wb_wen_q;
    wb_waddr_d  = wb_waddr_q;
    wb_wdata_d  = wb_wdata_q;
    wb_result_d = wb_result_q;
    cnt_d       = cnt_q;
    hang_d      = hang_q;

    // A load wins over a drain, so a simultaneous drain and load stays valid.
    if (rsp_take) begin
      wb_valid_d  = 1'b1;
      wb_wen_d    = cop_wen;
      wb_waddr_d  = cop_waddr;
      wb_wdata_d  = cop_wdata;
      wb_result_d = cop_result;
    end else if (wb_ready) begin
      wb_valid_d = 1'b0;
    end else begin
      wb_valid_d = wb_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (dec_valid) begin
          enc_d   = dec_enc;
          rs1_d   = dec_rs1;
          rs2_d   = dec_rs2;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (cop_insn_ack) begin
          cnt_d   = {CW{1'b0}};
          state_d = ST_WAIT;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_WAIT: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CW'(1);
        end else begin
          cnt_d = cnt_q;
        end
        // The hang flag only reports; the sequencer keeps waiting.
        if (rsp_take) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_HANG) begin
          hang_d = 1'b1;
        end else begin
          hang_d = hang_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that discards any in-flight work.
  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q     <= ST_IDLE;
      enc_q       <= 32'd0;
      rs1_q       <= 32'd0;
      rs2_q       <= 32'd0;
      wb_valid_q  <= 1'b0;
      wb_wen_q    <= 1'b0;
      wb_waddr_q  <= 5'd0;
      wb_wdata_q  <= 32'd0;
      wb_result_q <= 3'd0;
      cnt_q       <= {CW{1'b0}};
      hang_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      enc_q       <= enc_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      wb_valid_q  <= wb_valid_d;
      wb_wen_q    <= wb_wen_d;
      wb_waddr_q  <= wb_waddr_d;
      wb_wdata_q  <= wb_wdata_d;
      wb_result_q <= wb_result_d;
      cnt_q       <= cnt_d;
      hang_q      <= hang_d;
    end
  end

endmodule

// File: tb/tb_cop_insn_issue.sv
// Self-checking bench for cop_insn_issue: directed scenarios followed by
// random traffic, all compared every cycle against a transaction-phase model.
module tb_cop_insn_issue;

  localparam int TMO = 8;
  localparam int PH_IDLE = 0;
  localparam int PH_REQ  = 1;
  localparam int PH_WAIT = 2;

  logic        g_clk;
  logic        g_reset;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_enc;
  logic [31:0] dec_rs1;
  logic [31:0] dec_rs2;
  logic        cpu_insn_req;
  logic        cop_insn_ack;
  logic [31:0] cpu_insn_enc;
  logic [31:0] cpu_rs1;
  logic [31:0] cpu_rs2;
  logic        cop_insn_rsp;
  logic        cpu_insn_ack;
  logic        cop_wen;
  logic [4:0]  cop_waddr;
  logic [31:0] cop_wdata;
  logic [2:0]  cop_result;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_wen;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic [2:0]  wb_result;
  logic        busy;
  logic        cop_hang;

  cop_insn_issue #(.TIMEOUT_CYCLES(TMO), .CW(4)) dut (
    .g_clk(g_clk), .g_reset(g_reset),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .dec_enc(dec_enc), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .cpu_insn_req(cpu_insn_req), .cop_insn_ack(cop_insn_ack),
    .cpu_insn_enc(cpu_insn_enc), .cpu_rs1(cpu_rs1), .cpu_rs2(cpu_rs2),
    .cop_insn_rsp(cop_insn_rsp), .cpu_insn_ack(cpu_insn_ack),
    .cop_wen(cop_wen), .cop_waddr(cop_waddr), .cop_wdata(cop_wdata),
    .cop_result(cop_result),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_wen(wb_wen),
    .wb_waddr(wb_waddr), .wb_wdata(wb_wdata), .wb_result(wb_result),
    .busy(busy), .cop_hang(cop_hang)
  );

  // Free-running clock.
  initial g_clk = 1'b0;
  always #5 g_clk = ~g_clk;

  int n_cmp;
  int n_mis;
  int req_seen;
  bit chk_en;

  // Reference model: which phase the single outstanding instruction is in,
  // what was latched for it, the parked writeback and the wait-time count.
  int          m_phase;
  logic [31:0] m_enc, m_rs1, m_rs2;
  bit          m_wbv;
  logic        m_wen;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  logic [2:0]  m_result;
  bit          m_hang;
  int          m_wait_n;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase  = PH_IDLE;
    m_enc    = 32'd0; m_rs1 = 32'd0; m_rs2 = 32'd0;
    m_wbv    = 1'b0;
    m_wen    = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0; m_result = 3'd0;
    m_hang   = 1'b0;
    m_wait_n = 0;
  endtask

  task automatic quiet_inputs();
    dec_valid    = 1'b0;
    cop_insn_ack = 1'b0;
    cop_insn_rsp = 1'b0;
  endtask

  // One clock cycle: inputs are already applied (at the falling edge);
  // compare all outputs against the model, advance the model, move on to
  // the next falling edge.
  task automatic step();
    bit e_ready, e_req, e_ack;
    e_ready = !g_reset && (m_phase == PH_IDLE);
    e_req   = !g_reset && (m_phase == PH_REQ);
    e_ack   = !g_reset && (m_phase == PH_WAIT) && cop_insn_rsp && (!m_wbv || wb_ready);
    #1;
    if (chk_en) begin
      check_val("dec_ready", 32'(dec_ready), 32'(e_ready));
      check_val("cpu_insn_req", 32'(cpu_insn_req), 32'(e_req));
      check_val("cpu_insn_ack", 32'(cpu_insn_ack), 32'(e_ack));
      check_val("busy", 32'(busy), 32'(m_phase != PH_IDLE));
      check_val("cpu_insn_enc", cpu_insn_enc, m_enc);
      check_val("cpu_rs1", cpu_rs1, m_rs1);
      check_val("cpu_rs2", cpu_rs2, m_rs2);
      check_val("wb_valid", 32'(wb_valid), 32'(m_wbv));
      check_val("wb_wen", 32'(wb_wen), 32'(m_wen));
      check_val("wb_waddr", 32'(wb_waddr), 32'(m_waddr));
      check_val("wb_wdata", wb_wdata, m_wdata);
      check_val("wb_result", 32'(wb_result), 32'(m_result));
      check_val("cop_hang", 32'(cop_hang), 32'(m_hang));
    end
    if (cpu_insn_req === 1'b1) req_seen++;
    if (g_reset) begin
      model_reset();
    end else begin
      if (e_ack) begin
        m_wbv = 1'b1; m_wen = cop_wen; m_waddr = cop_waddr;
        m_wdata = cop_wdata; m_result = cop_result;
      end else if (wb_ready) begin
        m_wbv = 1'b0;
      end
      if (m_phase == PH_IDLE) begin
        if (dec_valid) begin
          m_enc = dec_enc; m_rs1 = dec_rs1; m_rs2 = dec_rs2;
          m_phase = PH_REQ;
        end
      end else if (m_phase == PH_REQ) begin
        if (cop_insn_ack) begin
          m_phase = PH_WAIT;
          m_wait_n = 0;
        end
      end else begin
        m_wait_n++;
        if (e_ack) m_phase = PH_IDLE;
        else if (m_wait_n == TMO) m_hang = 1'b1;
      end
    end
    @(posedge g_clk);
    @(negedge g_clk);
  endtask

  initial begin
    n_cmp = 0; n_mis = 0; req_seen = 0;
    chk_en = 1'b0;
    model_reset();
    g_reset = 1'b1;
    quiet_inputs();
    dec_enc = 32'd0; dec_rs1 = 32'd0; dec_rs2 = 32'd0;
    cop_wen = 1'b0; cop_waddr = 5'd0; cop_wdata = 32'd0; cop_result = 3'd0;
    wb_ready = 1'b0;
    @(negedge g_clk);

    // Reset: first cycle unchecked (state unknown), second checked.
    step();
    chk_en = 1'b1;
    step();
    g_reset = 1'b0;
    #1 check_val("post_reset_dec_ready", 32'(dec_ready), 32'd1);
    check_val("post_reset_busy", 32'(busy), 32'd0);

    // Single instruction: ack immediately, rsp two cycles into WAIT.
    req_seen = 0;
    dec_valid = 1'b1; dec_enc = 32'h0000_102B; dec_rs1 = 32'h1111_1111; dec_rs2 = 32'h2222_2222;
    step();
    dec_valid = 1'b0; cop_insn_ack = 1'b1;
    step();
    cop_insn_ack = 1'b0;
    step();
    step();
    cop_insn_rsp = 1'b1; cop_wen = 1'b1; cop_waddr = 5'd5; cop_wdata = 32'hDEAD_BEEF; cop_result = 3'd0;
    step();
    cop_insn_rsp = 1'b0;
    check_val("single_req_cycles", 32'(req_seen), 32'd1);
    check_val("single_wb_valid", 32'(wb_valid), 32'd1);
    check_val("single_wb_wdata", wb_wdata, 32'hDEAD_BEEF);
    check_val("single_wb_waddr", 32'(wb_waddr), 32'd5);
    check_val("single_wb_wen", 32'(wb_wen), 32'd1);
    check_val("single_wb_result", 32'(wb_result), 32'd0);

    // Ack delayed by 4 cycles while the decode inputs keep changing.
    dec_valid = 1'b1; dec_enc = 32'hA5A5_0001; dec_rs1 = 32'h3333_3333; dec_rs2 = 32'h4444_4444;
    step();
    dec_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      dec_enc = $urandom; dec_rs1 = $urandom; dec_rs2 = $urandom;
      cop_insn_ack = (i == 4);
      #1;
      check_val("hold_enc", cpu_insn_enc, 32'hA5A5_0001);
      check_val("hold_rs1", cpu_rs1, 32'h3333_3333);
      check_val("hold_rs2", cpu_rs2, 32'h4444_4444);
      step();
    end
    cop_insn_ack = 1'b0;

    // Backpressure: previous writeback still parked, wb_ready low.
    cop_insn_rsp = 1'b1; cop_wen = 1'b1; cop_waddr = 5'd9; cop_wdata = 32'h0BAD_F00D; cop_result = 3'd3;
    for (int i = 0; i < 3; i++) begin
      #1 check_val("bp_ack_low", 32'(cpu_insn_ack), 32'd0);
      step();
    end
    wb_ready = 1'b1;
    #1 check_val("bp_ack_high", 32'(cpu_insn_ack), 32'd1);
    step();
    cop_insn_rsp = 1'b0; wb_ready = 1'b0;
    check_val("bp_wb_valid", 32'(wb_valid), 32'd1);
    check_val("bp_wb_wdata", wb_wdata, 32'h0BAD_F00D);

    // Timeout: no response for more than TMO WAIT cycles, then a late one.
    wb_ready = 1'b1;
    dec_valid = 1'b1; dec_enc = $urandom;
    step();
    dec_valid = 1'b0; cop_insn_ack = 1'b1;
    step();
    cop_insn_ack = 1'b0;
    for (int i = 0; i < TMO - 1; i++) step();
    check_val("hang_before", 32'(cop_hang), 32'd0);
    step();
    check_val("hang_after", 32'(cop_hang), 32'd1);
    step();
    step();
    cop_insn_rsp = 1'b1; cop_wdata = 32'h1357_9BDF;
    step();
    cop_insn_rsp = 1'b0;
    check_val("late_wb_valid", 32'(wb_valid), 32'd1);
    check_val("late_wb_wdata", wb_wdata, 32'h1357_9BDF);
    check_val("hang_sticky", 32'(cop_hang), 32'd1);

    // Reset pulse while in WAIT discards the transaction.
    dec_valid = 1'b1; dec_enc = $urandom;
    step();
    dec_valid = 1'b0; cop_insn_ack = 1'b1;
    step();
    cop_insn_ack = 1'b0;
    step();
    step();
    g_reset = 1'b1;
    step();
    g_reset = 1'b0;
    check_val("rst_wait_busy", 32'(busy), 32'd0);
    check_val("rst_wait_wb_valid", 32'(wb_valid), 32'd0);
    check_val("rst_wait_hang", 32'(cop_hang), 32'd0);
    cop_insn_rsp = 1'b1;
    #1 check_val("rst_wait_no_ack", 32'(cpu_insn_ack), 32'd0);
    step();
    cop_insn_rsp = 1'b0;

    // Random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      g_reset      = ($urandom_range(0, 99) < 2);
      dec_valid    = ($urandom_range(0, 1) == 1);
      dec_enc      = $urandom; dec_rs1 = $urandom; dec_rs2 = $urandom;
      cop_insn_ack = ($urandom_range(0, 9) < 4);
      cop_insn_rsp = ($urandom_range(0, 9) < 4);
      cop_wen      = 1'($urandom);
      cop_waddr    = 5'($urandom);
      cop_wdata    = $urandom;
      cop_result   = 3'($urandom);
      wb_ready     = ($urandom_range(0, 9) < 6);
      step();
    end
    g_reset = 1'b0;
    quiet_inputs();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
